// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding and frame geometry.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte output port of the UART receive framer: valid/ready data plus status pulses.
interface uart_rx_framer_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      data_out_valid;
    logic                      data_out_ready;
    logic                      frame_error;
    logic                      overrun;
    logic                      rx_busy;

    modport master (
        output data_out, data_out_valid, frame_error, overrun, rx_busy,
        input  data_out_ready
    );

    modport slave (
        input  data_out, data_out_valid, frame_error, overrun, rx_busy,
        output data_out_ready
    );

endinterface

// File: rtl/uart_rx_framer_sync.sv
// Two-stage synchroniser for asynchronous pin inputs; resets to all ones (idle-high lines).
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: mid-bit sampling framer with a single-entry valid/ready holding register.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    uart_rx_framer_if.master    rx
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;

    localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0]     SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT    = BIT_IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    synchronizer #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    state_e                    state_q,   state_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic [UART_DATA_BITS-1:0] data_q,    data_d;
    logic                      valid_q,   valid_d;
    logic                      ferr_q,    ferr_d;
    logic                      ovr_q,     ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && rx.data_out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_BIT) state_d   = STOP;
                    else                       bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        // A drain on the commit edge frees the register for the new byte.
                        if (!valid_q || rx.data_out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx.data_out       = data_q;
    assign rx.data_out_valid = valid_q;
    assign rx.frame_error    = ferr_q;
    assign rx.overrun        = ovr_q;
    assign rx.rx_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 10 clocks per bit.
module tb_uart_rx_framer;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic serial_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framer_if rx_if ();

    uart_rx_framer #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx        (rx_if)
    );

    // Observers: handshaken bytes, pulse cycle counts, last valid rising edge.
    logic [7:0] hs_q[$];
    int   ferr_cnt   = 0;
    int   ovr_cnt    = 0;
    int   last_rise  = -1;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_if.data_out_valid === 1'b1 && rx_if.data_out_ready === 1'b1)
            hs_q.push_back(rx_if.data_out);
        if (rx_if.frame_error === 1'b1) ferr_cnt++;
        if (rx_if.overrun === 1'b1)     ovr_cnt++;
        if (rx_if.data_out_valid === 1'b1 && valid_prev !== 1'b1) last_rise = cyc;
        valid_prev = rx_if.data_out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        serial_in = v;
        idle_cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        serial_in = 1'b1;
    endtask

    function automatic logic [7:0] hs_at(input int idx);
        if (idx < hs_q.size()) return hs_q[idx];
        return 8'hxx;
    endfunction

    int n0;
    int f0;
    int o0;
    int start_cyc;
    int lat;
    logic [7:0] b96;

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        rx_if.data_out_ready = 1'b0;
        idle_cycles(3);

        check("reset_data",  32'(rx_if.data_out),       32'h00);
        check("reset_valid", 32'(rx_if.data_out_valid), 32'h0);
        check("reset_ferr",  32'(rx_if.frame_error),    32'h0);
        check("reset_ovr",   32'(rx_if.overrun),        32'h0);
        check("reset_busy",  32'(rx_if.rx_busy),        32'h0);

        rst = 1'b0;
        idle_cycles(3);

        // Single frame with ready held high.
        rx_if.data_out_ready = 1'b1;
        n0 = hs_q.size();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        idle_cycles(5);
        lat = last_rise - start_cyc;
        check("a5_count",   32'(hs_q.size()),           32'(n0 + 1));
        check("a5_data",    32'(hs_at(n0)),             32'hA5);
        check("a5_latency", 32'(lat >= 95 && lat <= 99), 32'h1);
        check("a5_ferr",    32'(ferr_cnt),              32'h0);
        check("a5_ovr",     32'(ovr_cnt),               32'h0);
        check("a5_valid",   32'(rx_if.data_out_valid),  32'h0);
        check("a5_hold",    32'(rx_if.data_out),        32'hA5);

        // Back-to-back frames, no idle gap.
        n0 = hs_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_cycles(5);
        check("b2b_count", 32'(hs_q.size()), 32'(n0 + 2));
        check("b2b_first", 32'(hs_at(n0)),     32'h00);
        check("b2b_second",32'(hs_at(n0 + 1)), 32'hFF);

        // Start-bit glitch of 3 cycles.
        n0 = hs_q.size();
        serial_in = 1'b0;
        idle_cycles(3);
        serial_in = 1'b1;
        idle_cycles(2);
        check("glitch_busy_hi", 32'(rx_if.rx_busy), 32'h1);
        idle_cycles(5);
        check("glitch_busy_lo", 32'(rx_if.rx_busy), 32'h0);
        idle_cycles(10);
        check("glitch_no_byte", 32'(hs_q.size()), 32'(n0));
        send_frame(8'h3C, 1'b1);
        idle_cycles(5);
        check("glitch_next_cnt",  32'(hs_q.size()), 32'(n0 + 1));
        check("glitch_next_data", 32'(hs_at(n0)),   32'h3C);

        // Stop bit forced low.
        n0 = hs_q.size();
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b0);
        idle_cycles(20);
        check("ferr_pulse", 32'(ferr_cnt),             32'(f0 + 1));
        check("ferr_nobyte",32'(hs_q.size()),          32'(n0));
        check("ferr_valid", 32'(rx_if.data_out_valid), 32'h0);
        check("ferr_busy",  32'(rx_if.rx_busy),        32'h0);
        send_frame(8'h3C, 1'b1);
        idle_cycles(5);
        check("ferr_next_cnt",  32'(hs_q.size()),    32'(n0 + 1));
        check("ferr_next_data", 32'(hs_at(n0)),      32'h3C);
        check("ferr_next_hold", 32'(rx_if.data_out), 32'h3C);

        // Overrun with consumer stalled.
        rx_if.data_out_ready = 1'b0;
        n0 = hs_q.size();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        idle_cycles(10);
        send_frame(8'h22, 1'b1);
        idle_cycles(5);
        check("ovr_data",   32'(rx_if.data_out),       32'h11);
        check("ovr_valid",  32'(rx_if.data_out_valid), 32'h1);
        check("ovr_pulse",  32'(ovr_cnt),              32'(o0 + 1));
        check("ovr_nobyte", 32'(hs_q.size()),          32'(n0));
        rx_if.data_out_ready = 1'b1;
        idle_cycles(3);
        check("ovr_drain_cnt",  32'(hs_q.size()),           32'(n0 + 1));
        check("ovr_drain_data", 32'(hs_at(n0)),             32'h11);
        check("ovr_drain_valid",32'(rx_if.data_out_valid),  32'h0);

        // Reset during bit 4 of 0x96, released during bit 7.
        b96 = 8'h96;
        n0 = hs_q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b96[i]);
        serial_in = b96[4];
        idle_cycles(3);
        rst = 1'b1;
        #1;
        check("rst_mid_data",  32'(rx_if.data_out),       32'h00);
        check("rst_mid_valid", 32'(rx_if.data_out_valid), 32'h0);
        check("rst_mid_busy",  32'(rx_if.rx_busy),        32'h0);
        idle_cycles(7);
        drive_bit(b96[5]);
        drive_bit(b96[6]);
        serial_in = b96[7];
        idle_cycles(4);
        rst = 1'b0;
        idle_cycles(6);
        drive_bit(1'b1);
        idle_cycles(20);
        check("rst_no_byte", 32'(hs_q.size()),          32'(n0));
        check("rst_idle",    32'(rx_if.rx_busy),        32'h0);
        check("rst_novalid", 32'(rx_if.data_out_valid), 32'h0);
        send_frame(8'h69, 1'b1);
        idle_cycles(5);
        check("rst_next_cnt",  32'(hs_q.size()), 32'(n0 + 1));
        check("rst_next_data", 32'(hs_at(n0)),   32'h69);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
